// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the PC / instruction-fetch unit: FSM states, PC source
// select codes, the reset NOP and the base opcodes seen by the decoder.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetchState_e;

    localparam logic [1:0]  PC_TARGET = 2'b00;
    localparam logic [1:0]  PC_PLUS4  = 2'b01;
    localparam logic [1:0]  PC_HOLD   = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0]  OP_LOAD   = 7'h03;
    localparam logic [6:0]  OP_IMM    = 7'h13;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_REG    = 7'h33;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_JAL    = 7'h6F;

endpackage

// File: rtl/pc_fetch_unit.sv
// Program counter plus single-outstanding instruction fetch: a 3-state FSM
// drives the memory request, captures the response and decodes its fields.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetchReq,
    input  logic            pcWrite,
    input  logic [1:0]      pcSelect,
    input  logic [XLEN-1:0] targetAddr,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemValid,
    input  logic [XLEN-1:0] imemRdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic [XLEN-1:0] instr,
    output logic [6:0]      opCode,
    output logic [2:0]      funct3,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            instrValid,
    output logic            busy,
    output logic            misalignErr,
    output logic            seqErr
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] NOP_X   = XLEN'(NOP_INSTR);

    fetchState_e     state_r;
    fetchState_e     nextState_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pcNext_s;
    logic [XLEN-1:0] instr_r;
    logic            instrValid_r;
    logic            misalignErr_r;
    logic            seqErr_r;
    logic            capture_s;
    logic            misalignNext_s;
    logic            seqErrNext_s;

    // Next-state, next-PC and error-pulse decode; PC only moves while idle.
    always_comb begin
        nextState_s    = state_r;
        pcNext_s       = pc_r;
        capture_s      = 1'b0;
        misalignNext_s = 1'b0;
        seqErrNext_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pcWrite) begin
                    case (pcSelect)
                        PC_TARGET: begin
                            pcNext_s       = {targetAddr[XLEN-1:2], 2'b00};
                            misalignNext_s = (targetAddr[1:0] != 2'b00);
                        end
                        PC_PLUS4: pcNext_s = pcPlus4;
                        default:  pcNext_s = pc_r;
                    endcase
                end else begin
                    pcNext_s = pc_r;
                end
                // A same-cycle pcWrite lands first, so the fetch sees the new PC.
                if (fetchReq) begin
                    nextState_s = ST_REQ;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_REQ, ST_WAIT: begin
                seqErrNext_s = fetchReq | pcWrite;
                if (imemValid) begin
                    capture_s   = 1'b1;
                    nextState_s = ST_IDLE;
                end else begin
                    nextState_s = ST_WAIT;
                end
            end
            default: nextState_s = ST_IDLE;
        endcase
    end

    // State, PC, instruction register and one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pc_r          <= RESET_PC;
            instr_r       <= NOP_X;
            instrValid_r  <= 1'b0;
            misalignErr_r <= 1'b0;
            seqErr_r      <= 1'b0;
        end else begin
            state_r       <= nextState_s;
            pc_r          <= pcNext_s;
            if (capture_s) begin
                instr_r <= imemRdata;
            end else begin
                instr_r <= instr_r;
            end
            instrValid_r  <= capture_s;
            misalignErr_r <= misalignNext_s;
            seqErr_r      <= seqErrNext_s;
        end
    end

    // PC is frozen while busy, so it doubles as the stable fetch address.
    assign busy        = (state_r != ST_IDLE);
    assign imemReq     = busy;
    assign imemAddr    = pc_r;
    assign pc          = pc_r;
    assign pcPlus4     = pc_r + PC_STEP;
    assign instr       = instr_r;
    assign instrValid  = instrValid_r;
    assign misalignErr = misalignErr_r;
    assign seqErr      = seqErr_r;

    assign opCode = instr_r[6:0];
    assign funct3 = instr_r[14:12];
    assign rd     = instr_r[11:7];
    assign rs1    = instr_r[19:15];
    assign rs2    = instr_r[24:20];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: inputs driven and outputs checked on the
// falling edge against hand-computed values.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetchReq;
    logic        pcWrite;
    logic [1:0]  pcSelect;
    logic [31:0] targetAddr;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemValid;
    logic [31:0] imemRdata;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [31:0] instr;
    logic [6:0]  opCode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        instrValid;
    logic        busy;
    logic        misalignErr;
    logic        seqErr;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .fetchReq(fetchReq), .pcWrite(pcWrite),
        .pcSelect(pcSelect), .targetAddr(targetAddr), .imemReq(imemReq),
        .imemAddr(imemAddr), .imemValid(imemValid), .imemRdata(imemRdata),
        .pc(pc), .pcPlus4(pcPlus4), .instr(instr), .opCode(opCode),
        .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2),
        .instrValid(instrValid), .busy(busy), .misalignErr(misalignErr),
        .seqErr(seqErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic writePc(input logic [1:0] sel, input logic [31:0] tgt);
        pcWrite    = 1'b1;
        pcSelect   = sel;
        targetAddr = tgt;
        step();
        pcWrite    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetchReq = 1'b0; pcWrite = 1'b0; pcSelect = 2'b00;
        targetAddr = 32'h0; imemValid = 1'b0; imemRdata = 32'h0;
        @(negedge clk);
        step();
        rst = 1'b0;

        // reset state
        checkVal("rst_pc", pc, 32'h0);
        checkVal("rst_instr", instr, 32'h0000_0013);
        checkVal("rst_imemReq", {31'h0, imemReq}, 32'h0);
        checkVal("rst_instrValid", {31'h0, instrValid}, 32'h0);
        checkVal("rst_busy", {31'h0, busy}, 32'h0);

        // zero-wait fetch from address 0
        fetchReq = 1'b1; step(); fetchReq = 1'b0;
        checkVal("f0_imemReq", {31'h0, imemReq}, 32'h1);
        checkVal("f0_imemAddr", imemAddr, 32'h0);
        checkVal("f0_validEarly", {31'h0, instrValid}, 32'h0);
        imemValid = 1'b1; imemRdata = 32'h0000_0033; step(); imemValid = 1'b0;
        checkVal("f0_instrValid", {31'h0, instrValid}, 32'h1);
        checkVal("f0_opCode", {25'h0, opCode}, 32'h33);
        checkVal("f0_busyDone", {31'h0, busy}, 32'h0);
        step();
        checkVal("f0_validPulse", {31'h0, instrValid}, 32'h0);

        // sequential increments, hold codes and wraparound
        writePc(2'b01, 32'h0); writePc(2'b01, 32'h0); writePc(2'b01, 32'h0);
        checkVal("inc_pc", pc, 32'd12);
        checkVal("inc_pcPlus4", pcPlus4, 32'd16);
        writePc(2'b10, 32'h0000_0500);
        checkVal("hold10_pc", pc, 32'd12);
        writePc(2'b11, 32'h0000_0500);
        checkVal("hold11_pc", pc, 32'd12);
        writePc(2'b00, 32'hFFFF_FFFC);
        checkVal("tgt_pc", pc, 32'hFFFF_FFFC);
        checkVal("tgt_noMisalign", {31'h0, misalignErr}, 32'h0);
        writePc(2'b01, 32'h0);
        checkVal("wrap_pc", pc, 32'h0);

        // misaligned target
        writePc(2'b00, 32'h0000_0102);
        checkVal("mis_pc", pc, 32'h0000_0100);
        checkVal("mis_err", {31'h0, misalignErr}, 32'h1);
        step();
        checkVal("mis_pulse", {31'h0, misalignErr}, 32'h0);

        // fetch with 5 wait cycles and a pcWrite injected while busy
        fetchReq = 1'b1; step(); fetchReq = 1'b0;
        checkVal("w_busy", {31'h0, busy}, 32'h1);
        checkVal("w_addr0", imemAddr, 32'h0000_0100);
        step();
        pcWrite = 1'b1; pcSelect = 2'b01; step(); pcWrite = 1'b0;
        checkVal("w_seqErr", {31'h0, seqErr}, 32'h1);
        checkVal("w_pcHeld", pc, 32'h0000_0100);
        checkVal("w_addr1", imemAddr, 32'h0000_0100);
        step();
        checkVal("w_seqPulse", {31'h0, seqErr}, 32'h0);
        step(); step();
        checkVal("w_addr2", imemAddr, 32'h0000_0100);
        checkVal("w_noValid", {31'h0, instrValid}, 32'h0);
        imemValid = 1'b1; imemRdata = 32'h0020_C1B3; step(); imemValid = 1'b0;
        checkVal("w_instrValid", {31'h0, instrValid}, 32'h1);
        checkVal("w_instr", instr, 32'h0020_C1B3);
        checkVal("w_funct3", {29'h0, funct3}, 32'd4);
        checkVal("w_rd", {27'h0, rd}, 32'd3);
        checkVal("w_rs1", {27'h0, rs1}, 32'd1);
        checkVal("w_rs2", {27'h0, rs2}, 32'd2);

        // stray response while idle is ignored
        imemValid = 1'b1; imemRdata = 32'hDEAD_BEEF; step(); imemValid = 1'b0;
        checkVal("idle_instr", instr, 32'h0020_C1B3);
        checkVal("idle_noValid", {31'h0, instrValid}, 32'h0);

        // reset aborts an outstanding fetch
        fetchReq = 1'b1; step(); fetchReq = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        checkVal("ra_imemReq", {31'h0, imemReq}, 32'h0);
        checkVal("ra_pc", pc, 32'h0);
        imemValid = 1'b1; imemRdata = 32'h1234_5678; step(); imemValid = 1'b0;
        checkVal("ra_instr", instr, 32'h0000_0013);
        checkVal("ra_noValid", {31'h0, instrValid}, 32'h0);

        // same-cycle pcWrite and fetchReq: fetch uses the new PC
        fetchReq = 1'b1; pcWrite = 1'b1; pcSelect = 2'b00; targetAddr = 32'h0000_0040;
        step();
        fetchReq = 1'b0; pcWrite = 1'b0;
        checkVal("co_imemAddr", imemAddr, 32'h0000_0040);
        checkVal("co_busy", {31'h0, busy}, 32'h1);
        fetchReq = 1'b1; step(); fetchReq = 1'b0;
        checkVal("co_seqErr", {31'h0, seqErr}, 32'h1);
        imemValid = 1'b1; imemRdata = 32'h0000_0063; step(); imemValid = 1'b0;
        checkVal("co_opCode", {25'h0, opCode}, 32'h63);
        step();
        checkVal("co_noRefetch", {31'h0, busy}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
